usrt_rx_deframer: RTL and testbench
===================================

// Module: usrt_rx_deframer
// PURPOSE
//  Receive-side deframer of the USRT peripheral: samples the synchronous serial line Tx on
//  each bit strobe, strips start/stop (and optional parity) bits, and queues whole bytes
//  in a small FIFO. The APB slave pops bytes from it to drive pRData on read transfers.
//  Sits directly between the serial pin and the APB register block, in the pClk domain.
// PARAMETERS
//  DEPTH    4   FIFO entries (power of two, >=2)
//  DATA_W   8   data bits per frame (fixed 8 in this release; width of rData)
// PORTS
//  pClk       in   1       system/APB clock; all logic on rising edge
//  pReset     in   1       asynchronous, active-low reset
//  bit_tick   in   1       one-pClk-cycle strobe per serial bit (uClk edge, made upstream)
//  Tx         in   1       serial line from remote transmitter; idle high
//  rReady     in   1       APB side pops the head byte when rReady && rValid
//  err_clr    in   1       one-cycle pulse; clears all sticky error flags
//  rData      out  DATA_W  FIFO head byte (valid only while rValid)
//  rValid     out  1       FIFO not empty
//  rFull      out  1       FIFO holds DEPTH bytes
//  frame_err  out  1       sticky: stop bit sampled 0
//  overrun    out  1       sticky: good frame arrived while FIFO full
//  parity_err out  1       sticky: parity mismatch (0 when parity compiled out)
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, FIFO empty, rData=0, rValid=0,
//    rFull=0, all error flags 0, shift reg and bit counter 0.
//  - Frame: start(0), 8 data LSB first, [parity], stop(1). Tx sampled only on bit_tick;
//    Tx ignored on other cycles. No oversampling, no glitch filtering.
//  - FSM: IDLE --tick&Tx==0--> DATA (cnt=0); IDLE stays on tick&Tx==1.
//    DATA: each tick shift Tx into bit[cnt], cnt++; after 8th bit -> PARITY if enabled
//    else STOP. PARITY: one tick, compute mismatch -> STOP.
//    STOP: on tick -> IDLE and evaluate: Tx==0 -> frame_err=1, byte dropped;
//    parity mismatch -> parity_err=1, byte dropped; else push byte.
//  - Back-to-back frames: start bit may arrive on the tick right after STOP; no idle gap.
//  - Latency: byte visible on rData/rValid the pClk cycle after the stop-bit tick.
//  - Push when full: accepted if a pop occurs the same cycle (count unchanged); otherwise
//    byte dropped, overrun=1, FIFO contents untouched.
//  - Pop when empty: ignored, no flag. Simultaneous push+pop on empty: push only.
//  - Pointers wrap modulo DEPTH; count uses log2(DEPTH)+1 bits.
//  - err_clr and a new error event same cycle: set wins.
//  - Reset mid-frame discards the partial byte; next frame requires a fresh start bit.
// CONFIGURATION
//  USRT_PARITY_EN defined: frame carries an even-parity bit after data bit 7; PARITY
//    state present; mismatch sets parity_err and drops the byte.
//  Undefined: 10-bit frame, PARITY state absent, parity_err tied 0.
// STRUCTURE
//  usrt_pkg: rx_state_t enum (IDLE, DATA, PARITY, STOP), USRT_DATA_W=8,
//    USRT_START_BIT=1'b0, USRT_STOP_BIT=1'b1, parity function shared with the TX side.
//  Sub-module usrt_sync_fifo (DEPTH, DATA_W): push/pop/full/empty/count, pop-aware full;
//    reused later by the transmit path. Deframer FSM stays in this module.
// TESTING
//  1 Reset: pReset=0 mid-frame, release -> all outputs 0, next frame 0xA5 received intact.
//  2 Single frame 0x39 (bits 1,0,0,1,1,1,0,0 LSB first, stop 1) -> rValid=1, rData=8'h39
//    one cycle after stop tick; rReady pulse -> rValid=0.
//  3 Stop bit 0 on frame 0x55 -> frame_err=1, rValid stays 0; err_clr -> frame_err=0.
//  4 DEPTH+1 frames (0x01..0x05) with rReady=0 -> rFull=1, overrun=1, pops return
//    0x01..0x04 in order; repeat with pop on 5th stop-tick cycle -> no overrun, 0x05 kept.
//  5 USRT_PARITY_EN: 0x03 with parity 0 -> accepted; 0x07 with parity 0 -> parity_err=1,
//    dropped. Without macro: same 0x07 10-bit frame accepted, parity_err=0.
//  6 Back-to-back 0xFF,0x00 with no idle tick, Tx toggling between ticks -> both bytes
//    received, no errors.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared USRT types and constants for the receive and transmit paths.
// The transmitter uses the same even-parity helper as the receiver.
package usrt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int   USRT_DATA_W    = 8;
  localparam logic USRT_START_BIT = 1'b0;
  localparam logic USRT_STOP_BIT  = 1'b1;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic usrt_even_parity(input logic [USRT_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/usrt_sync_fifo.sv
// Single-clock byte FIFO with pop-aware full. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is reported on push_drop.
module usrt_sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     push_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign empty     = (count == '0);
  assign full      = (count == CNT_MAX);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign push_drop = push && !push_ok;
  assign head      = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop_ok)      count <= count + CNT_ONE;
      else if (pop_ok && !push_ok) count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/usrt_rx_deframer.sv
// USRT receive deframer: samples Tx on bit_tick, strips framing, queues bytes.
// Define USRT_PARITY_EN to expect an even-parity bit between data bit 7 and stop.
module usrt_rx_deframer
  import usrt_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = USRT_DATA_W
) (
  input  logic                   pClk,
  input  logic                   pReset,
  input  logic                   bit_tick,
  input  logic                   Tx,
  input  logic                   rReady,
  input  logic                   err_clr,
  output logic [DATA_W-1:0]      rData,
  output logic                   rValid,
  output logic                   rFull,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   parity_err,
  output rx_state_t              state,
  output logic [$clog2(DEPTH):0] fill
);

  // Handshake: the head byte on rData is consumed on any cycle where rValid && rReady.
  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  rx_state_t         next_state;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] shreg;
  logic              push;
  logic              set_ferr;
  logic              set_perr;
  logic              push_drop;
  logic              fifo_empty;
  logic              par_bad;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
    set_ferr   = 1'b0;
    set_perr   = 1'b0;
    if (bit_tick) begin
      case (state)
        IDLE: if (Tx == USRT_START_BIT) next_state = DATA;
        DATA: begin
          if (cnt == LAST_BIT) begin
`ifdef USRT_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end
        end
`ifdef USRT_PARITY_EN
        PARITY: next_state = STOP;
`endif
        STOP: begin
          next_state = IDLE;
          // A bad stop bit outranks a parity mismatch; either way the byte is dropped.
          if (Tx != USRT_STOP_BIT) set_ferr = 1'b1;
          else if (par_bad)        set_perr = 1'b1;
          else                     push     = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (bit_tick) begin
      if (state == IDLE) begin
        cnt <= '0;
      end else if (state == DATA) begin
        shreg[cnt] <= Tx;
        cnt        <= cnt + 3'd1;
      end
    end
  end

`ifdef USRT_PARITY_EN
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      par_bad <= 1'b0;
    end else if (bit_tick) begin
      if (state == IDLE)        par_bad <= 1'b0;
      else if (state == PARITY) par_bad <= (usrt_even_parity(shreg) != Tx);
    end
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) parity_err <= 1'b0;
    else         parity_err <= set_perr || (parity_err && !err_clr);
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Sticky flags: a new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= set_ferr || (frame_err && !err_clr);
      overrun   <= push_drop || (overrun && !err_clr);
    end
  end

  usrt_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (pClk),
    .rst_n     (pReset),
    .push      (push),
    .push_data (shreg),
    .pop       (rReady),
    .head      (rData),
    .full      (rFull),
    .empty     (fifo_empty),
    .count     (fill),
    .push_drop (push_drop)
  );

  assign rValid = !fifo_empty;

endmodule

// File: tb/tb_usrt_rx_deframer.sv
// Directed bench for usrt_rx_deframer: frame driver, queue-based reference model
// checked every cycle, plus literal checks on hand-computed results.
module tb_usrt_rx_deframer;
  import usrt_pkg::*;

  localparam int DEPTH = 4;

  logic       pClk = 1'b0;
  logic       pReset = 1'b0;
  logic       bit_tick = 1'b0;
  logic       Tx = 1'b1;
  logic       rReady = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rData;
  logic       rValid, rFull, frame_err, overrun, parity_err;
  rx_state_t  state;
  logic [2:0] fill;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: expected FIFO contents and sticky flags.
  logic [7:0] exp_q[$];
  logic       m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
  logic       ev_push = 1'b0, ev_ferr = 1'b0, ev_perr = 1'b0;
  logic [7:0] ev_data = 8'h00;
  bit         cmp_en = 1'b0;

  usrt_rx_deframer #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .pClk       (pClk),
    .pReset     (pReset),
    .bit_tick   (bit_tick),
    .Tx         (Tx),
    .rReady     (rReady),
    .err_clr    (err_clr),
    .rData      (rData),
    .rValid     (rValid),
    .rFull      (rFull),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .state      (state),
    .fill       (fill)
  );

  always #5 pClk = ~pClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a completed frame event pushes, drops or flags; rReady pops the head.
  always @(posedge pClk or negedge pReset) begin
    bit do_pop;
    bit was_full;
    if (!pReset) begin
      exp_q.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      m_perr = 1'b0;
    end else begin
      do_pop   = rReady && (exp_q.size() != 0);
      was_full = (exp_q.size() == DEPTH);
      if (do_pop) void'(exp_q.pop_front());
      m_ferr = ev_ferr || (m_ferr && !err_clr);
      m_perr = ev_perr || (m_perr && !err_clr);
      m_ovr  = (ev_push && was_full && !do_pop) || (m_ovr && !err_clr);
      if (ev_push && (!was_full || do_pop)) exp_q.push_back(ev_data);
    end
  end

  always @(negedge pClk) begin
    if (cmp_en) begin
      chk("rValid", 32'(rValid), 32'(exp_q.size() != 0));
      chk("rFull", 32'(rFull), 32'(exp_q.size() == DEPTH));
      chk("fill", 32'(fill), 32'(exp_q.size()));
      chk("rData", 32'(rData), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("parity_err", 32'(parity_err), 32'(m_perr));
    end
  end

  // One serial bit: tick cycle, then a non-tick cycle with Tx deliberately flipped.
  task automatic tick_bit(input logic b);
    Tx = b;
    bit_tick = 1'b1;
    @(posedge pClk); #1;
    bit_tick = 1'b0;
    Tx = ~b;
    @(posedge pClk); #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input logic pop_stop);
    logic ferr, perr;
    ferr = (stop_b == 1'b0);
`ifdef USRT_PARITY_EN
    perr = !ferr && (par_b != ^d);
`else
    perr = 1'b0 && par_b;
`endif
    tick_bit(1'b0);
    for (int i = 0; i < 8; i++) tick_bit(d[i]);
`ifdef USRT_PARITY_EN
    tick_bit(par_b);
`endif
    Tx = stop_b;
    bit_tick = 1'b1;
    rReady = pop_stop;
    ev_push = !ferr && !perr;
    ev_ferr = ferr;
    ev_perr = perr;
    ev_data = d;
    @(posedge pClk); #1;
    bit_tick = 1'b0;
    Tx = ~stop_b;
    rReady = 1'b0;
    ev_push = 1'b0;
    ev_ferr = 1'b0;
    ev_perr = 1'b0;
    @(posedge pClk); #1;
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, 1'b1, ^d, 1'b0);
  endtask

  task automatic pop_byte(input logic [7:0] exp);
    chk("pop_data", 32'(rData), 32'(exp));
    rReady = 1'b1;
    @(posedge pClk); #1;
    rReady = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge pClk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge pClk);
    #1;
    cmp_en = 1'b1;
    pReset = 1'b1;
    @(posedge pClk); #1;

    // Reset state, then a reset in the middle of a frame.
    chk("rst_rValid", 32'(rValid), 32'h0);
    chk("rst_rData", 32'(rData), 32'h0);
    chk("rst_flags", {29'h0, frame_err, overrun, parity_err}, 32'h0);
    chk("rst_state", 32'(state), 32'(IDLE));
    tick_bit(1'b0);
    tick_bit(1'b1);
    tick_bit(1'b1);
    pReset = 1'b0;
    @(posedge pClk); #1;
    chk("midrst_state", 32'(state), 32'(IDLE));
    chk("midrst_fill", 32'(fill), 32'h0);
    pReset = 1'b1;
    @(posedge pClk); #1;
    send_good(8'hA5);
    chk("a5_valid", 32'(rValid), 32'h1);
    pop_byte(8'hA5);

    // Single frame and pop.
    send_good(8'h39);
    chk("39_valid", 32'(rValid), 32'h1);
    pop_byte(8'h39);
    chk("39_popped", 32'(rValid), 32'h0);

    // Bad stop bit.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    chk("ferr_set", 32'(frame_err), 32'h1);
    chk("ferr_novalid", 32'(rValid), 32'h0);
    pulse_clr();
    chk("ferr_clr", 32'(frame_err), 32'h0);

    // Overrun, then the same fill with a pop on the fifth stop tick.
    for (int i = 1; i <= 5; i++) send_good(8'(i));
    chk("ovr_full", 32'(rFull), 32'h1);
    chk("ovr_set", 32'(overrun), 32'h1);
    pop_byte(8'h01);
    pop_byte(8'h02);
    pop_byte(8'h03);
    pop_byte(8'h04);
    chk("ovr_empty", 32'(rValid), 32'h0);
    pulse_clr();
    for (int i = 1; i <= 4; i++) send_good(8'(i));
    send_frame(8'h05, 1'b1, 1'b0, 1'b1);
    chk("nopov_ovr", 32'(overrun), 32'h0);
    chk("nopov_full", 32'(rFull), 32'h1);
    pop_byte(8'h02);
    pop_byte(8'h03);
    pop_byte(8'h04);
    pop_byte(8'h05);

    // Parity handling.
    send_frame(8'h03, 1'b1, 1'b0, 1'b0);
    pop_byte(8'h03);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
`ifdef USRT_PARITY_EN
    chk("perr_set", 32'(parity_err), 32'h1);
    chk("perr_drop", 32'(rValid), 32'h0);
    pulse_clr();
    chk("perr_clr", 32'(parity_err), 32'h0);
`else
    chk("noparity_perr", 32'(parity_err), 32'h0);
    pop_byte(8'h07);
`endif

    // Back-to-back frames without an idle bit.
    send_good(8'hFF);
    send_good(8'h00);
    chk("b2b_fill", 32'(fill), 32'h2);
    pop_byte(8'hFF);
    pop_byte(8'h00);
    chk("b2b_flags", {29'h0, frame_err, overrun, parity_err}, 32'h0);

    repeat (2) @(posedge pClk);
    #1;
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
